// File: rtl/fifo_ptr_sync_rx_if.sv
// Bundles the write-pointer receiver signals for the read-clock domain.
// Latency: none (wiring only).
// Backpressure: none; every signal is a continuously-valid level.
interface fifo_ptr_sync_rx_if #(
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0] wptr_gray;
    logic [ADDRSIZE:0] rq_wptr_gray;
    logic [ADDRSIZE:0] rq_wptr_bin;
    logic              wptr_adv;
    logic [ADDRSIZE:0] wptr_delta;
    logic              err_clr;
    logic              err_overrun;
    logic [7:0]        err_cnt;

    // Write-domain side: launches the Gray pointer and owns the error clear.
    modport master (
        output wptr_gray,
        output err_clr,
        input  rq_wptr_gray,
        input  rq_wptr_bin,
        input  wptr_adv,
        input  wptr_delta,
        input  err_overrun,
        input  err_cnt
    );

    // Receiver side: the synchroniser block itself.
    modport slave (
        input  wptr_gray,
        input  err_clr,
        output rq_wptr_gray,
        output rq_wptr_bin,
        output wptr_adv,
        output wptr_delta,
        output err_overrun,
        output err_cnt
    );
endinterface

// File: rtl/fifo_ptr_sync_rx.sv
// Gray write-pointer synchroniser into rclk with binary convert, advance/delta and overrun check.
// Latency: STAGES edges to rq_wptr_gray, STAGES+1 edges to bin/adv/delta/err outputs.
// Backpressure: none; samples every rclk edge. Overrun checking exists only with FIFO_PTR_SYNC_ERR_CHECK_EN.
module fifo_ptr_sync_rx #(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    fifo_ptr_sync_rx_if.slave       ptr_if
);

    localparam int PW = ADDRSIZE + 1;
    // An advance strictly larger than the FIFO depth is impossible in a healthy FIFO.
    localparam logic [ADDRSIZE:0] DEPTH = PW'(1) << ADDRSIZE;

    // Fewer than two flops is not a synchroniser; more than four only adds latency.
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "fifo_ptr_sync_rx: STAGES must be 2..4");
    end

    logic [ADDRSIZE:0] sync_q [STAGES];
    logic [ADDRSIZE:0] bin_d;
    logic [ADDRSIZE:0] delta_d;
    logic              adv_d;
    logic [ADDRSIZE:0] bin_q;
    logic [ADDRSIZE:0] delta_q;
    logic              adv_q;

    // Plain flop chain; only sync_q[0] sees the asynchronous input.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ptr_if.wptr_gray;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            bin_d[i] = ^(sync_q[STAGES-1] >> i);
        end
        delta_d = bin_d - bin_q;
        adv_d   = (bin_d != bin_q);
    end

    // Register the binary pointer with its per-cycle advance and modulo delta.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            bin_q   <= '0;
            delta_q <= '0;
            adv_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            delta_q <= delta_d;
            adv_q   <= adv_d;
        end
    end

    assign ptr_if.rq_wptr_gray = sync_q[STAGES-1];
    assign ptr_if.rq_wptr_bin  = bin_q;
    assign ptr_if.wptr_delta   = delta_q;
    assign ptr_if.wptr_adv     = adv_q;

`ifdef FIFO_PTR_SYNC_ERR_CHECK_EN
    logic       overrun_d;
    logic       err_ovr_q;
    logic [7:0] err_cnt_q;

    assign overrun_d = (delta_d > DEPTH);

    // Sticky overrun flag and saturating event count; a new event beats a same-edge clear.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            err_ovr_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (overrun_d) begin
            err_ovr_q <= 1'b1;
            if (ptr_if.err_clr) begin
                err_cnt_q <= 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end else if (ptr_if.err_clr) begin
            err_ovr_q <= 1'b0;
            err_cnt_q <= '0;
        end
    end

    assign ptr_if.err_overrun = err_ovr_q;
    assign ptr_if.err_cnt     = err_cnt_q;
`else
    // Error checking compiled out: outputs parked at zero, clear input ignored.
    logic              unused_err_clr;
    logic [ADDRSIZE:0] unused_depth;
    assign unused_err_clr     = ptr_if.err_clr;
    assign unused_depth       = DEPTH;
    assign ptr_if.err_overrun = 1'b0;
    assign ptr_if.err_cnt     = '0;
`endif

endmodule
